// File: rtl/if_fetch_pkg.sv
// Shared definitions for the instruction-fetch slice: bus widths, reset
// constants, fetch FSM encodings and the fetch-issue helper.
package if_fetch_pkg;

   localparam int InstAddrBus = 32;
   localparam int InstBus     = 32;

   localparam logic [InstBus-1:0]     ZeroWord   = 32'h0000_0000;
   localparam logic                   RstEnable  = 1'b1;
   localparam logic [InstAddrBus-1:0] DefResetPc = 32'hBFC0_0000;
   localparam logic [InstAddrBus-1:0] PcStep     = 32'h0000_0004;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FETCH = 3'd1,
      S_HOLD  = 3'd2,
      S_DRAIN = 3'd3,
      S_FAULT = 3'd4
   } fetch_state_e;

   // A fetch may be issued unless alignment checking is on and the low PC bits are set.
   function automatic logic fetch_issue(input logic [1:0] pc_lo, input logic chk_en);
      return (!chk_en) || (pc_lo == 2'b00);
   endfunction

endpackage

// File: rtl/if_hold_buf.sv
// One-entry skid register that parks a fetched instruction and its PC while
// the downstream stage is stalled.
module if_hold_buf
   import if_fetch_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   load,
   input  logic                   clear,
   input  logic [InstBus-1:0]     din_inst,
   input  logic [InstAddrBus-1:0] din_pc,
   output logic                   valid,
   output logic [InstBus-1:0]     dout_inst,
   output logic [InstAddrBus-1:0] dout_pc
);

   // Skid entry: clear wins over load so a flush never leaves stale data behind.
   always_ff @(posedge clk) begin
      if ((rst == RstEnable) || clear) begin
         valid     <= 1'b0;
         dout_inst <= ZeroWord;
         dout_pc   <= ZeroWord;
      end else if (load) begin
         valid     <= 1'b1;
         dout_inst <= din_inst;
         dout_pc   <= din_pc;
      end
   end

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: PC ownership, req/ack fetch, stall skid, delayed
// branch and flush redirect. Optional macro IF_ADDR_CHECK_EN adds fetch address-error reporting.
module if_fetch
   import if_fetch_pkg::*;
#(
   parameter logic [InstAddrBus-1:0] RESET_PC = DefResetPc
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   stall_i,
   input  logic                   branch_flag_i,
   input  logic [InstAddrBus-1:0] branch_target_i,
   input  logic                   flush_i,
   input  logic [InstAddrBus-1:0] flush_pc_i,
   output logic                   inst_req,
   output logic [InstAddrBus-1:0] inst_addr,
   input  logic                   inst_ack,
   input  logic [InstBus-1:0]     inst_rdata,
   output logic [InstAddrBus-1:0] if_pc,
   output logic [InstBus-1:0]     if_inst,
   output logic                   if_valid,
   output logic                   if_excp_adel
);

`ifdef IF_ADDR_CHECK_EN
   localparam logic ChkEn = 1'b1;
`else
   localparam logic ChkEn = 1'b0;
`endif

   fetch_state_e           state_r;
   logic [InstAddrBus-1:0] pc_r;
   logic                   br_pend_r;
   logic [InstAddrBus-1:0] br_target_r;
   logic [InstAddrBus-1:0] fl_target_r;
   logic                   inst_req_r;
   logic                   excp_r;

   logic [InstAddrBus-1:0] adv_pc_s;
   logic                   take_s;
   logic                   hold_load_s;
   logic                   hold_clr_s;
   logic                   hold_valid_s;
   logic [InstBus-1:0]     hold_inst_s;
   logic [InstAddrBus-1:0] hold_pc_s;

   assign take_s       = inst_req_r && inst_ack;
   assign inst_req     = inst_req_r;
   assign if_excp_adel = excp_r;

`ifdef IF_ADDR_CHECK_EN
   assign inst_addr = pc_r;
`else
   assign inst_addr = {pc_r[InstAddrBus-1:2], 2'b00};
`endif

   // PC after a delivery: a same-cycle branch beats a pending one, else sequential (wraps silently).
   always_comb begin
      if (branch_flag_i) begin
         adv_pc_s = branch_target_i;
      end else if (br_pend_r) begin
         adv_pc_s = br_target_r;
      end else begin
         adv_pc_s = pc_r + PcStep;
      end
   end

   // Skid control: park on ack-under-stall, drop on release or flush.
   always_comb begin
      hold_load_s = 1'b0;
      hold_clr_s  = 1'b0;
      if (flush_i) begin
         hold_clr_s = 1'b1;
      end else if ((state_r == S_HOLD) && !stall_i) begin
         hold_clr_s = 1'b1;
      end else if ((state_r == S_FETCH) && take_s && stall_i) begin
         hold_load_s = 1'b1;
      end else begin
         hold_load_s = 1'b0;
      end
   end

   if_hold_buf u_hold_buf (
      .clk       (clk),
      .rst       (rst),
      .load      (hold_load_s),
      .clear     (hold_clr_s),
      .din_inst  (inst_rdata),
      .din_pc    (pc_r),
      .valid     (hold_valid_s),
      .dout_inst (hold_inst_s),
      .dout_pc   (hold_pc_s)
   );

   // Fetch FSM with registered request and IF/ID-facing outputs.
   always_ff @(posedge clk) begin
      if (rst == RstEnable) begin
         state_r     <= S_IDLE;
         pc_r        <= RESET_PC;
         br_pend_r   <= 1'b0;
         br_target_r <= ZeroWord;
         fl_target_r <= ZeroWord;
         inst_req_r  <= 1'b0;
         excp_r      <= 1'b0;
         if_pc       <= ZeroWord;
         if_inst     <= ZeroWord;
         if_valid    <= 1'b0;
      end else if (flush_i) begin
         br_pend_r <= 1'b0;
         if_valid  <= 1'b0;
         case (state_r)
            S_FETCH: begin
               // An unacked request must be drained before the redirect can be issued.
               if (take_s || !inst_req_r) begin
                  pc_r       <= flush_pc_i;
                  state_r    <= S_FETCH;
                  inst_req_r <= fetch_issue(flush_pc_i[1:0], ChkEn);
               end else begin
                  fl_target_r <= flush_pc_i;
                  state_r     <= S_DRAIN;
                  inst_req_r  <= 1'b1;
               end
            end
            S_DRAIN: begin
               if (take_s) begin
                  pc_r       <= flush_pc_i;
                  state_r    <= S_FETCH;
                  inst_req_r <= fetch_issue(flush_pc_i[1:0], ChkEn);
               end else begin
                  fl_target_r <= flush_pc_i;
               end
            end
            default: begin
               pc_r       <= flush_pc_i;
               state_r    <= S_FETCH;
               inst_req_r <= fetch_issue(flush_pc_i[1:0], ChkEn);
            end
         endcase
      end else begin
         if (!stall_i) begin
            if_valid <= 1'b0;
         end
         if (branch_flag_i && (state_r != S_DRAIN)) begin
            br_pend_r   <= 1'b1;
            br_target_r <= branch_target_i;
         end
         case (state_r)
            S_IDLE: begin
               state_r    <= S_FETCH;
               inst_req_r <= fetch_issue(pc_r[1:0], ChkEn);
            end
            S_FETCH: begin
               if (take_s) begin
                  if (!stall_i) begin
                     if_valid   <= 1'b1;
                     if_inst    <= inst_rdata;
                     if_pc      <= pc_r;
                     excp_r     <= 1'b0;
                     pc_r       <= adv_pc_s;
                     br_pend_r  <= 1'b0;
                     inst_req_r <= fetch_issue(adv_pc_s[1:0], ChkEn);
                  end else begin
                     state_r    <= S_HOLD;
                     inst_req_r <= 1'b0;
                  end
               end
`ifdef IF_ADDR_CHECK_EN
               else if (!inst_req_r) begin
                  if (!stall_i) begin
                     if_valid <= 1'b1;
                     if_inst  <= ZeroWord;
                     if_pc    <= pc_r;
                     excp_r   <= 1'b1;
                     state_r  <= S_FAULT;
                  end
               end
`endif
            end
            S_HOLD: begin
               if (!stall_i) begin
                  if_valid   <= hold_valid_s;
                  if_inst    <= hold_inst_s;
                  if_pc      <= hold_pc_s;
                  excp_r     <= 1'b0;
                  pc_r       <= adv_pc_s;
                  br_pend_r  <= 1'b0;
                  state_r    <= S_FETCH;
                  inst_req_r <= fetch_issue(adv_pc_s[1:0], ChkEn);
               end
            end
            S_DRAIN: begin
               // Data returned for the squashed fetch is dropped.
               if (take_s) begin
                  pc_r       <= fl_target_r;
                  state_r    <= S_FETCH;
                  inst_req_r <= fetch_issue(fl_target_r[1:0], ChkEn);
               end
            end
`ifdef IF_ADDR_CHECK_EN
            S_FAULT: begin
               inst_req_r <= 1'b0;
            end
`endif
            default: begin
               state_r    <= S_IDLE;
               inst_req_r <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/if_fetch.md
# if_fetch

Instruction-fetch stage: owns the program counter, issues word fetches to instruction memory over a req/ack handshake, and presents fetched instructions to the IF/ID pipeline register. Handles pipeline stall, delayed-branch redirect (the delay-slot fetch always completes) and flush/exception redirect (the in-flight fetch is discarded). Sits between instruction ROM/bus and `if_id`.

## Interface
- RESET_PC, 32'hBFC0_0000, first fetch address after reset.
- clk  in  1  clock, rising edge.
- rst  in  1  reset rst, synchronous, active-high.
- stall_i  in  1  downstream stall; IF outputs must hold.
- branch_flag_i  in  1  one-cycle branch-taken pulse from ID.
- branch_target_i  in  32  branch destination.
- flush_i  in  1  exception/flush pulse from ctrl.
- flush_pc_i  in  32  handler/restart address.
- inst_req  out  1  fetch request.
- inst_addr  out  32  fetch address; stable while inst_req high and not acked.
- inst_ack  in  1  memory accepted and returned data this cycle; may be high in the same cycle req rises.
- inst_rdata  in  32  instruction, valid only with inst_ack.
- if_pc  out  32  PC of delivered instruction.
- if_inst  out  32  delivered instruction.
- if_valid  out  1  if_pc/if_inst hold a real instruction.
- if_excp_adel  out  1  address-error on fetch (see Configuration).

## Operation
- Registers: pc, state, hold_buf (inst+pc), br_pend + br_target, fl_target.
- States: IDLE, FETCH, HOLD, DRAIN, FAULT. inst_req = (state==FETCH or DRAIN); inst_addr = pc.
- IDLE: entered on rst; -> FETCH on first edge with rst low.
- FETCH, ack, no stall: deliver (if_valid<=1, if_inst<=rdata, if_pc<=pc); pc <= br_pend ? br_target : pc+4; clear br_pend.
- FETCH, ack, stall: rdata/pc into hold_buf, -> HOLD (req low).
- HOLD, stall low: deliver hold_buf; advance pc as above; -> FETCH.
- branch_flag_i: if acked or HOLD-released in same cycle, use branch_target_i directly; otherwise set br_pend/br_target. Accepted regardless of stall.
- flush_i (highest priority, beats branch and stall): clears br_pend, hold_buf, if_valid<=0 next edge. FETCH+ack or HOLD or FAULT: pc<=flush_pc_i, -> FETCH. FETCH without ack: fl_target<=flush_pc_i, -> DRAIN. DRAIN: keep req on old addr; on ack discard data, pc<=fl_target, -> FETCH. Flush in DRAIN updates fl_target.
- Outputs update only when stall_i low (or flush); otherwise hold. Cycle with no delivery and no stall: if_valid<=0, if_pc/if_inst keep value.
- PC arithmetic 32-bit, wraps 0xFFFF_FFFC -> 0x0000_0000 silently.
- rst mid-operation: outstanding request abandoned, memory must tolerate dropped req.

## Timing
- Reset values: if_pc=0, if_inst=0, if_valid=0, if_excp_adel=0, inst_req=0, pc=RESET_PC, br_pend=0.
- Latency: ack at edge N -> if_valid high after edge N. Zero-wait memory sustains one instruction per cycle.
- First inst_req: cycle after the first edge with rst low.
- Branch to target: the delay slot is delivered first, then target fetch issued next cycle.

## Configuration
- IF_ADDR_CHECK_EN defined: when entering FETCH with pc[1:0]!=0, no request is issued. Next edge (stall low): if_valid=1, if_inst=0, if_pc=pc, if_excp_adel=1, -> FAULT, wait for flush_i. if_excp_adel clears on next delivery.
- Undefined: inst_addr = {pc[31:2],2'b00}, no FAULT state, if_excp_adel tied 0.

## Structure
- Shared defines package: bus widths (InstAddrBus, InstBus), ZeroWord, RstEnable, state encodings, default RESET_PC.
- One natural sub-module: if_hold_buf (one-entry skid register, load/clear/valid).

## Test plan
- Reset, zero-wait ack -> req at 0xBFC00000 one cycle after rst low; if_pc 0xBFC00000, 0xBFC00004, 0xBFC00008 on consecutive cycles.
- Ack while stall_i high for 3 cycles -> req drops, outputs frozen, instruction 0x24010005 delivered the cycle after stall falls, no loss or duplicate.
- branch_flag_i target 0xBFC00100 while fetch at 0xBFC00008 waits 2 cycles -> 0xBFC00008 delivered, next inst_addr 0xBFC00100.
- flush_i pc 0xBFC00380 with 3-cycle-latency fetch outstanding -> inst_addr stays until ack, data discarded (if_valid 0), next req 0xBFC00380.
- flush_i and branch_flag_i and stall_i same cycle -> flush wins, br_pend cleared, next fetch 0xBFC00380.
- IF_ADDR_CHECK_EN, flush to 0xBFC00382 -> no req, if_excp_adel=1, if_inst=0, if_pc=0xBFC00382; flush to 0xBFC00380 resumes.
